lap_recorder: RTL and testbench
===============================

Name: lap_recorder

Overview:
- Lap/split memory between stopwatch_logic and display_driver.
- Captures the live hours/minutes/seconds/centisec on each lap press into a ring buffer of DEPTH entries.
- Drives the display either with live time (LIVE) or with a recalled lap (RECALL).
- Runs on the 100 Hz timing clock; button inputs are already debounced levels.

Parameters:
- DEPTH, 8, number of stored laps; power of two, 2..16.
- CW, $clog2(DEPTH)+1, width of lap count/index; derived, not overridden.

Ports:
- clk_100Hz  input  1  100 Hz timing clock, rising-edge.
- rst  input  1  asynchronous, active-high reset (S0).
- hours_i  input  8  live hours from stopwatch_logic.
- minutes_i  input  8  live minutes.
- seconds_i  input  8  live seconds.
- centisec_i  input  8  live centiseconds.
- lap_btn  input  1  debounced level; rising edge = lap capture (LIVE) or exit (RECALL).
- recall_btn  input  1  debounced level; rising edge = enter recall / step to older lap.
- clr_btn  input  1  debounced level; rising edge = erase all laps.
- hours_o  output  8  time to display_driver.
- minutes_o  output  8
- seconds_o  output  8
- centisec_o  output  8
- recall_mode  output  1  high in RECALL.
- lap_idx  output  CW  1-based position of the shown lap (1 = oldest retained); 0 in LIVE.
- lap_count  output  CW  laps stored, 0..DEPTH.
- full  output  1  lap_count == DEPTH.

Behaviour:
- Reset (async, rst=1): state LIVE; wr_ptr=0, rd_ptr=0, lap_count=0, full=0, recall_mode=0, lap_idx=0; all time outputs 0; button edge registers 0. Buffer contents are don't-care (never shown while lap_count=0).
- Edge detect: each button is registered. An event = btn & ~btn_q, evaluated at the same clock edge. A held button produces exactly one event.
- Priority per cycle: clr > lap > recall.
- All outputs are registered. In LIVE, time_o equals time_i delayed by 1 clk_100Hz cycle.
- Capture (LIVE, lap event): writes the time_i value at that edge into mem[wr_ptr]; wr_ptr += 1 mod DEPTH; lap_count += 1, saturating at DEPTH.
  - When full, the oldest entry is overwritten and lap_count stays DEPTH (see Optional Feature).
  - Values are stored bit-for-bit; no arithmetic on time fields.
- LIVE, recall event:
  - lap_count=0: ignored.
  - Otherwise: state -> RECALL; rd_ptr = wr_ptr-1 (newest); lap_idx = lap_count.
  - Next cycle, time_o = mem[rd_ptr].
- RECALL, recall event: step to the next older entry; lap_idx -= 1; rd_ptr -= 1 mod DEPTH. From lap_idx=1, wrap to the newest (lap_idx=lap_count, rd_ptr=wr_ptr-1).
- RECALL, lap event: state -> LIVE; lap_idx=0. No capture on this press.
- RECALL display is frozen: time_i changes are not shown. stopwatch_logic continues counting independently.
- clr event (any state): lap_count=0, wr_ptr=0, full=0, state LIVE, lap_idx=0. Any lap/recall event in the same cycle is discarded.
- lap and recall simultaneous in LIVE: capture only; recall ignored.
- Reset mid-RECALL: immediate return to reset values, regardless of clock.

Optional Feature:
- Macro: LAP_FULL_LOCK_EN.
- Defined: a lap event while full=1 is dropped. Buffer, wr_ptr and lap_count are unchanged, so the first DEPTH laps are preserved.
- Undefined: ring overwrite of the oldest entry as described above.

Decomposition:
- Package stopwatch_pkg:
  - typedef time_t: struct of four 8-bit fields (hours, minutes, seconds, centisec).
  - typedef enum lap_state_e {LIVE, RECALL}.
  - localparam LAP_DEPTH_DEFAULT = 8.
- One natural sub-module: edge_pulse (1-bit rising-edge detector with async active-high reset), instantiated three times.
- Buffer is an inferred register array inside lap_recorder.

Test Plan:
- Reset then no buttons; time_i = 00:01:02.03 -> next cycle time_o = 00:01:02.03; recall_mode=0, lap_count=0.
- Laps at 00:00:05.10, 00:00:09.20, 00:00:12.30, then recall x3 -> shows 12.30 (idx 3), 09.20 (idx 2), 05.10 (idx 1); 4th recall wraps to 12.30 (idx 3); lap press -> LIVE, idx 0, lap_count still 3.
- 9 laps with DEPTH=8, values centisec=1..9 -> lap_count=8, full=1; recall shows 9 (newest) then older down to 2. With LAP_FULL_LOCK_EN: newest shown = 8, oldest = 1.
- Recall press with lap_count=0 -> recall_mode stays 0, time_o tracks live.
- lap and recall rising in the same cycle in LIVE -> one capture, state LIVE. clr with lap in the same cycle -> lap_count=0, no capture.
- Assert rst asynchronously mid-RECALL (between clock edges) -> all outputs 0 and recall_mode=0 before the next edge. Held lap_btn for 50 cycles -> exactly one capture.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: time bundle, lap FSM states,
// default lap memory depth.
package stopwatch_pkg;

  typedef struct packed {
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic [7:0] centisec;
  } time_t;

  typedef enum logic {
    LIVE   = 1'b0,
    RECALL = 1'b1
  } lap_state_e;

  localparam int LAP_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a debounced button level.
// Pulse is combinational from the level and its registered copy.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_pulse
);

  logic r_q;

  // Remember last level so a held button fires only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= i_d;
  end

  assign o_pulse = i_d & ~r_q;

endmodule

// File: rtl/lap_recorder.sv
// Lap/split ring memory between stopwatch_logic and display_driver.
// Define LAP_FULL_LOCK_EN to drop laps once full instead of overwriting.
module lap_recorder
  import stopwatch_pkg::*;
#(
  parameter  int DEPTH = LAP_DEPTH_DEFAULT,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_100Hz,
  input  logic          rst,
  input  logic [7:0]    hours_i,
  input  logic [7:0]    minutes_i,
  input  logic [7:0]    seconds_i,
  input  logic [7:0]    centisec_i,
  input  logic          lap_btn,
  input  logic          recall_btn,
  input  logic          clr_btn,
  output logic [7:0]    hours_o,
  output logic [7:0]    minutes_o,
  output logic [7:0]    seconds_o,
  output logic [7:0]    centisec_o,
  output logic          recall_mode,
  output logic [CW-1:0] lap_idx,
  output logic [CW-1:0] lap_count,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);

  time_t         r_mem [DEPTH];
  time_t         r_time;
  lap_state_e    r_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_idx;
  logic          r_full;

  logic          w_lap_ev;
  logic          w_rec_ev;
  logic          w_clr_ev;
  logic          w_cap_ok;
  logic          w_wr_en;
  logic [PW-1:0] w_newest;
  logic [PW-1:0] w_older;
  logic [CW-1:0] w_cnt_nx;
  time_t         w_live;

  edge_pulse u_lap (
    .clk     (clk_100Hz),
    .rst     (rst),
    .i_d     (lap_btn),
    .o_pulse (w_lap_ev)
  );

  edge_pulse u_rec (
    .clk     (clk_100Hz),
    .rst     (rst),
    .i_d     (recall_btn),
    .o_pulse (w_rec_ev)
  );

  edge_pulse u_clr (
    .clk     (clk_100Hz),
    .rst     (rst),
    .i_d     (clr_btn),
    .o_pulse (w_clr_ev)
  );

  assign w_live = '{
    hours:    hours_i,
    minutes:  minutes_i,
    seconds:  seconds_i,
    centisec: centisec_i
  };

`ifdef LAP_FULL_LOCK_EN
  assign w_cap_ok = ~r_full;
`else
  assign w_cap_ok = 1'b1;
`endif

  assign w_newest = r_wr_ptr - PW'(1);
  assign w_older  = r_rd_ptr - PW'(1);
  assign w_cnt_nx = (r_count == CW'(DEPTH)) ?
                    r_count : r_count + CW'(1);

  assign w_wr_en = w_lap_ev & ~w_clr_ev &
                   (r_state == LIVE) & w_cap_ok;

  // Lap storage: plain register array, contents only read when count>0
  always_ff @(posedge clk_100Hz) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_live;
  end

  // Mode FSM, pointers, counters and registered display time
  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      r_state  <= LIVE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_full   <= 1'b0;
      r_time   <= '0;
    end else if (w_clr_ev) begin
      r_state  <= LIVE;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_full   <= 1'b0;
      r_time   <= w_live;
    end else begin
      case (r_state)
        LIVE: begin
          r_time <= w_live;
          if (w_lap_ev) begin
            if (w_cap_ok) begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              r_count  <= w_cnt_nx;
              r_full   <= (w_cnt_nx == CW'(DEPTH));
            end
          end else if (w_rec_ev && r_count != '0) begin
            r_state  <= RECALL;
            r_rd_ptr <= w_newest;
            r_idx    <= r_count;
            r_time   <= r_mem[w_newest];
          end
        end
        RECALL: begin
          if (w_lap_ev) begin
            r_state <= LIVE;
            r_idx   <= '0;
            r_time  <= w_live;
          end else if (w_rec_ev) begin
            if (r_idx == CW'(1)) begin
              r_idx    <= r_count;
              r_rd_ptr <= w_newest;
              r_time   <= r_mem[w_newest];
            end else begin
              r_idx    <= r_idx - CW'(1);
              r_rd_ptr <= w_older;
              r_time   <= r_mem[w_older];
            end
          end
        end
        default: r_state <= LIVE;
      endcase
    end
  end

  assign hours_o     = r_time.hours;
  assign minutes_o   = r_time.minutes;
  assign seconds_o   = r_time.seconds;
  assign centisec_o  = r_time.centisec;
  assign recall_mode = (r_state == RECALL);
  assign lap_idx     = r_idx;
  assign lap_count   = r_count;
  assign full        = r_full;

endmodule

// File: tb/tb_lap_recorder.sv
// Directed bench for lap_recorder (DEPTH=8): vector table plus
// hand sequences for ring wrap, held button and async reset.
module tb_lap_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] hh, mm, ss, cc;
  logic       lap, rec, clr;
  logic [7:0] ho, mo, so, co;
  logic       rm;
  logic [3:0] idx, cnt;
  logic       fl;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        lap;
    logic        rec;
    logic        clr;
    logic [31:0] tin;
    logic [31:0] tout;
    logic        rm;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic        full;
  } vec_t;

  vec_t vq[$];

  lap_recorder #(.DEPTH(8)) dut (
    .clk_100Hz  (clk),
    .rst        (rst),
    .hours_i    (hh),
    .minutes_i  (mm),
    .seconds_i  (ss),
    .centisec_i (cc),
    .lap_btn    (lap),
    .recall_btn (rec),
    .clr_btn    (clr),
    .hours_o    (ho),
    .minutes_o  (mo),
    .seconds_o  (so),
    .centisec_o (co),
    .recall_mode(rm),
    .lap_idx    (idx),
    .lap_count  (cnt),
    .full       (fl)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] t(int h, int m, int s, int c);
    return {8'(h), 8'(m), 8'(s), 8'(c)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(logic l, logic r, logic c, logic [31:0] ti,
                     logic [31:0] to, logic m, int i, int n, logic f);
    vec_t v;
    v.lap = l; v.rec = r; v.clr = c; v.tin = ti; v.tout = to;
    v.rm = m; v.idx = 4'(i); v.cnt = 4'(n); v.full = f;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settime(logic [31:0] v);
    {hh, mm, ss, cc} = v;
  endtask

  function automatic logic [31:0] tout();
    return {ho, mo, so, co};
  endfunction

  int newest;

  initial begin
    rst = 1'b1; lap = 0; rec = 0; clr = 0;
    settime(32'h0);
    step(); step();
    chk("rst_time", tout(), 32'h0);
    chk("rst_mode", 32'(rm), 32'h0);
    chk("rst_idx", 32'(idx), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_full", 32'(fl), 32'h0);
    rst = 1'b0;

    // lap rec clr | time in | time out | mode idx cnt full
    add(0,0,0, t(0,1,2,3),   t(0,1,2,3),   0,0,0,0);
    add(0,1,0, t(0,1,2,4),   t(0,1,2,4),   0,0,0,0);
    add(0,0,0, t(0,0,5,10),  t(0,0,5,10),  0,0,0,0);
    add(1,0,0, t(0,0,5,10),  t(0,0,5,10),  0,0,1,0);
    add(0,0,0, t(0,0,9,20),  t(0,0,9,20),  0,0,1,0);
    add(1,0,0, t(0,0,9,20),  t(0,0,9,20),  0,0,2,0);
    add(0,0,0, t(0,0,12,30), t(0,0,12,30), 0,0,2,0);
    add(1,0,0, t(0,0,12,30), t(0,0,12,30), 0,0,3,0);
    add(0,0,0, t(0,0,13,0),  t(0,0,13,0),  0,0,3,0);
    add(0,1,0, t(0,0,13,1),  t(0,0,12,30), 1,3,3,0);
    add(0,0,0, t(0,0,13,2),  t(0,0,12,30), 1,3,3,0);
    add(0,1,0, t(0,0,13,3),  t(0,0,9,20),  1,2,3,0);
    add(0,0,0, t(0,0,13,4),  t(0,0,9,20),  1,2,3,0);
    add(0,1,0, t(0,0,13,5),  t(0,0,5,10),  1,1,3,0);
    add(0,0,0, t(0,0,13,6),  t(0,0,5,10),  1,1,3,0);
    add(0,1,0, t(0,0,13,7),  t(0,0,12,30), 1,3,3,0);
    add(0,0,0, t(0,0,13,8),  t(0,0,12,30), 1,3,3,0);
    add(1,0,0, t(0,0,20,0),  t(0,0,20,0),  0,0,3,0);
    add(0,0,0, t(0,0,20,1),  t(0,0,20,1),  0,0,3,0);
    add(1,1,0, t(0,0,20,2),  t(0,0,20,2),  0,0,4,0);
    add(0,0,0, t(0,0,20,3),  t(0,0,20,3),  0,0,4,0);
    add(0,1,0, t(0,0,20,4),  t(0,0,20,2),  1,4,4,0);
    add(1,0,0, t(0,0,20,5),  t(0,0,20,5),  0,0,4,0);
    add(0,0,0, t(0,0,20,6),  t(0,0,20,6),  0,0,4,0);
    add(1,0,1, t(0,0,20,7),  t(0,0,20,7),  0,0,0,0);
    add(0,0,0, t(0,0,20,8),  t(0,0,20,8),  0,0,0,0);
    add(0,1,0, t(0,0,20,9),  t(0,0,20,9),  0,0,0,0);
    add(0,0,0, t(0,0,21,0),  t(0,0,21,0),  0,0,0,0);

    foreach (vq[k]) begin
      lap = vq[k].lap; rec = vq[k].rec; clr = vq[k].clr;
      settime(vq[k].tin);
      step();
      chk($sformatf("v%0d_time", k), tout(), vq[k].tout);
      chk($sformatf("v%0d_mode", k), 32'(rm), 32'(vq[k].rm));
      chk($sformatf("v%0d_idx", k), 32'(idx), 32'(vq[k].idx));
      chk($sformatf("v%0d_cnt", k), 32'(cnt), 32'(vq[k].cnt));
      chk($sformatf("v%0d_full", k), 32'(fl), 32'(vq[k].full));
    end
    lap = 0; rec = 0; clr = 0;

    // Nine laps into an 8-deep buffer
    for (int k = 1; k <= 9; k++) begin
      settime(t(0, 1, 0, k));
      lap = 1; step();
      lap = 0; step();
    end
    chk("ring_cnt", 32'(cnt), 32'd8);
    chk("ring_full", 32'(fl), 32'd1);
`ifdef LAP_FULL_LOCK_EN
    newest = 8;
`else
    newest = 9;
`endif
    settime(t(0, 2, 0, 0));
    for (int k = 0; k < 8; k++) begin
      rec = 1; step();
      rec = 0;
      chk($sformatf("ring%0d_time", k), tout(),
          t(0, 1, 0, newest - k));
      chk($sformatf("ring%0d_idx", k), 32'(idx), 32'(8 - k));
      step();
    end
    rec = 1; step(); rec = 0;
    chk("ring_wrap", tout(), t(0, 1, 0, newest));
    chk("ring_wrap_idx", 32'(idx), 32'd8);
    step();
    lap = 1; step(); lap = 0;
    chk("ring_exit_mode", 32'(rm), 32'd0);
    chk("ring_exit_cnt", 32'(cnt), 32'd8);
    step();

    // Held lap button: one capture only
    clr = 1; step(); clr = 0; step();
    chk("clr_cnt", 32'(cnt), 32'd0);
    chk("clr_full", 32'(fl), 32'd0);
    settime(t(3, 4, 5, 6));
    lap = 1;
    for (int k = 0; k < 50; k++) step();
    lap = 0; step();
    chk("held_cnt", 32'(cnt), 32'd1);
    settime(t(9, 9, 9, 9));
    rec = 1; step(); rec = 0;
    chk("held_val", tout(), t(3, 4, 5, 6));
    chk("held_mode", 32'(rm), 32'd1);
    chk("held_idx", 32'(idx), 32'd1);

    // Async reset between edges while in recall
    #2;
    rst = 1'b1;
    #1;
    chk("arst_time", tout(), 32'h0);
    chk("arst_mode", 32'(rm), 32'd0);
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_cnt", 32'(cnt), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_live", tout(), t(9, 9, 9, 9));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
